// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmit scheduler.
// A granted byte is serialised as start, data (LSB first), optional parity and stop bits, paced by baud_clk ticks.
module uart_tx_sched #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clk,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       txd,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PAR, STOP} state_t;

  localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       stopcnt_q, stopcnt_d;
  logic       par_q, par_d;
  logic       txd_q, txd_d;
  logic       grant_id_q, grant_id_d;
  logic       last_grant_q, last_grant_d;
  logic       frame_done_q, frame_done_d;
  logic       baud_clk_q;

  logic       tick;
  logic       grant0, grant1;
  logic       accept, winner;
  logic [7:0] acc_data;
  logic       acc_par;

  assign tick = baud_clk & ~baud_clk_q;

  // With both requesters pending, the one that did not own the last frame wins.
  assign grant0     = req0_valid & (~req1_valid | last_grant_q);
  assign grant1     = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = (state_q == IDLE) & grant0 & ~reset;
  assign req1_ready = (state_q == IDLE) & grant1 & ~reset;
  assign accept     = req0_ready | req1_ready;
  assign winner     = req1_ready;
  assign acc_data   = (winner ? req1_data : req0_data) & DATA_MASK;
  assign acc_par    = (^acc_data) ^ (PARITY == 2);

  // NOTE: every next-state variable is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    stopcnt_d    = stopcnt_q;
    par_d        = par_q;
    txd_d        = txd_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d         = acc_data;
          par_d        = acc_par;
          grant_id_d   = winner;
          last_grant_d = winner;
          state_d      = SYNC;
        end
      end
      SYNC: begin
        if (tick) begin
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          txd_d   = sr_q[0];
          cnt_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == 3'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              txd_d   = par_q;
              state_d = PAR;
            end else begin
              txd_d     = 1'b1;
              stopcnt_d = 1'b0;
              state_d   = STOP;
            end
          end else begin
            sr_d  = sr_q >> 1;
            txd_d = sr_q[1];
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          txd_d     = 1'b1;
          stopcnt_d = 1'b0;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (stopcnt_q == 1'(STOP_BITS - 1)) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            stopcnt_d = stopcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      stopcnt_q    <= 1'b0;
      par_q        <= 1'b0;
      txd_q        <= 1'b1;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      frame_done_q <= 1'b0;
      baud_clk_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      stopcnt_q    <= stopcnt_d;
      par_q        <= par_d;
      txd_q        <= txd_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      frame_done_q <= frame_done_d;
      baud_clk_q   <= baud_clk;
    end
  end

  assign txd        = txd_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_id_q;
  assign frame_done = frame_done_q;

endmodule
